// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a synchronous FIFO built around an external register file.
// Turns push/pop requests into write enable and addresses, and tracks occupancy and error flags.
module fifo_ctrl #(
  parameter int no_of_words     = 3,
  parameter int almost_full_th  = 6,
  parameter int almost_empty_th = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   clr_err,
  output logic                   w_en,
  output logic [no_of_words-1:0] write_address,
  output logic [no_of_words-1:0] read_address,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [no_of_words:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CW = no_of_words + 1;
  localparam logic [no_of_words:0] DEPTH    = CW'(1 << no_of_words);
  localparam logic [no_of_words:0] AF_TH    = CW'(almost_full_th);
  localparam logic [no_of_words:0] AE_TH    = CW'(almost_empty_th);

  logic [no_of_words-1:0] wr_ptr_q, wr_ptr_d;
  logic [no_of_words-1:0] rd_ptr_q, rd_ptr_d;
  logic [no_of_words:0]   count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   push_ok, pop_ok;

  // A push into a full FIFO is still accepted when a pop frees the head slot at the same edge.
  assign push_ok = wr & (~full_q | rd);
  assign pop_ok  = rd & ~empty_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    empty_d  = empty_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        empty_d  = 1'b0;
        full_d   = (count_d == DEPTH);
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
        full_d   = 1'b0;
        empty_d  = (count_d == '0);
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
    // A new error in the same cycle as clr_err wins over the clear.
    overflow_d  = (overflow_q  & ~clr_err) | (wr & ~push_ok);
    underflow_d = (underflow_q & ~clr_err) | (rd & ~pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_en          = push_ok;
  assign write_address = wr_ptr_q;
  assign read_address  = rd_ptr_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = (count_q >= AF_TH);
  assign almost_empty  = (count_q <= AE_TH);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based FIFO model plus an emulated storage array,
// compared on every falling edge, with literal expectations on directed boundary scenarios.
module tb_fifo_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic         clk = 1'b0;
  logic         reset, wr, rd, clr_err;
  logic         w_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [N-1:0] write_address, read_address;
  logic [N:0]   count;
  logic [7:0]   wdata;

  int passed = 0;
  int total  = 0;

  fifo_ctrl #(.no_of_words(N), .almost_full_th(AF), .almost_empty_th(AE)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .w_en(w_en), .write_address(write_address), .read_address(read_address),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Storage array emulation, written by the DUT's own write enable and address.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (w_en === 1'b1) mem[write_address] <= wdata;

  // Reference model: contents as a queue, pointers as plain modular counters.
  logic [7:0] q[$];
  int  m_wp, m_rp;
  bit  m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_wp  <= 0;
      m_rp  <= 0;
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else begin
      int  sz;
      bit  push, pop;
      sz   = q.size();
      push = wr && (sz < DEPTH || rd);
      pop  = rd && (sz > 0);
      m_ovf <= (m_ovf && !clr_err) || (wr && !push);
      m_unf <= (m_unf && !clr_err) || (rd && !pop);
      if (pop) begin
        void'(q.pop_front());
        m_rp <= (m_rp + 1) % DEPTH;
      end
      if (push) begin
        q.push_back(wdata);
        m_wp <= (m_wp + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      int sz;
      sz = q.size();
      check("count",        32'(count),         32'(sz));
      check("full",         32'(full),          32'(sz == DEPTH));
      check("empty",        32'(empty),         32'(sz == 0));
      check("almost_full",  32'(almost_full),   32'(sz >= AF));
      check("almost_empty", 32'(almost_empty),  32'(sz <= AE));
      check("write_address",32'(write_address), 32'(m_wp));
      check("read_address", 32'(read_address),  32'(m_rp));
      check("overflow",     32'(overflow),      32'(m_ovf));
      check("underflow",    32'(underflow),     32'(m_unf));
      check("w_en",         32'(w_en),          32'(wr && (sz < DEPTH || rd)));
      if (sz > 0) check("head_data", 32'(mem[read_address]), 32'(q[0]));
    end
  end

  task automatic set_in(input bit w, input bit r, input bit c);
    wr = w; rd = r; clr_err = c; wdata = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit w, input bit r, input bit c);
    set_in(w, r, c);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"},        32'(empty),         32'd1);
    check({tag, "_full"},         32'(full),          32'd0);
    check({tag, "_count"},        32'(count),         32'd0);
    check({tag, "_almost_empty"}, 32'(almost_empty),  32'd1);
    check({tag, "_almost_full"},  32'(almost_full),   32'd0);
    check({tag, "_read_address"}, 32'(read_address),  32'd0);
    check({tag, "_write_address"},32'(write_address), 32'd0);
    check({tag, "_overflow"},     32'(overflow),      32'd0);
    check({tag, "_underflow"},    32'(underflow),     32'd0);
    check({tag, "_w_en"},         32'(w_en),          32'd0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    #12 reset = 1'b0;
    #1 check_reset_values("reset_idle");
    tick();

    // Fill with eight pushes.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, 1'b0);
      #1;
      check("fill_w_en", 32'(w_en), 32'd1);
      check("fill_write_address", 32'(write_address), 32'(i));
      tick();
      if (i == 4) check("af_below_th", 32'(almost_full), 32'd0);
      if (i == 5) begin
        check("af_count6", 32'(count), 32'd6);
        check("af_at_th",  32'(almost_full), 32'd1);
      end
    end
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_wrap",  32'(write_address), 32'd0);

    // Push into full FIFO without a pop.
    set_in(1'b1, 1'b0, 1'b0);
    #1 check("ovf_w_en", 32'(w_en), 32'd0);
    tick();
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    check("fullrw_count", 32'(count), 32'd8);
    check("fullrw_full",  32'(full), 32'd1);
    check("fullrw_wa",    32'(write_address), 32'd4);
    check("fullrw_ra",    32'(read_address), 32'd4);

    // Drain, then pop on empty, then push+pop on empty.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ra",    32'(read_address), 32'd4);
    cyc(1'b0, 1'b1, 1'b0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_ra",   32'(read_address), 32'd4);
    check("unf_wa",   32'(write_address), 32'd4);
    cyc(1'b1, 1'b1, 1'b0);
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_empty", 32'(empty), 32'd0);
    check("emptyrw_ra",    32'(read_address), 32'd4);
    check("emptyrw_wa",    32'(write_address), 32'd5);
    cyc(1'b0, 1'b0, 1'b1);
    check("unf_clear", 32'(underflow), 32'd0);

    // Randomized traffic in fill-biased, drain-biased and balanced phases.
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      rp = 100 - wp;
      cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
          ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-operation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    check("pre_reset_count", 32'(count), 32'd2);
    set_in(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    #3 reset = 1'b0;
    tick();
    cyc(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
